// File: rtl/modn_count_pkg.sv
// Shared types and constants for the modulo-N count controller.
package modn_count_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic        MODE_UP     = 1'b0;
    localparam logic        MODE_DOWN   = 1'b1;
    localparam int unsigned MIN_MODULUS = 2;

endpackage

// File: rtl/modn_count_ctrl_if.sv
// Command/status bundle between a control agent and the modulo-N controller.
interface modn_count_ctrl_if #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned WRAPS_W = 4
);
    logic               start;
    logic               mode;
    logic [WIDTH-1:0]   modulus;
    logic [WRAPS_W-1:0] wraps;
    logic               hold;
    logic               stop;
    logic [WIDTH-1:0]   out;
    logic               busy;
    logic               wrap;
    logic               done;
    logic               err;

    modport master (
        output start, mode, modulus, wraps, hold, stop,
        input  out, busy, wrap, done, err
    );

    modport slave (
        input  start, mode, modulus, wraps, hold, stop,
        output out, busy, wrap, done, err
    );
endinterface

// File: rtl/modn_updown_core.sv
// Modulo-N up/down counter datapath: load value, single step and terminal wrap.
module modn_updown_core
    import modn_count_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] out,
    output logic             wrap_nxt
);

    logic [WIDTH-1:0] top;

    always_comb begin
        top      = n - WIDTH'(1);
        wrap_nxt = (dir == MODE_DOWN) ? (out == '0) : (out == top);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
        end else if (load) begin
            out <= (dir == MODE_DOWN) ? top : '0;
        end else if (en) begin
            if (wrap_nxt)
                out <= (dir == MODE_DOWN) ? top : '0;
            else if (dir == MODE_DOWN)
                out <= out - WIDTH'(1);
            else
                out <= out + WIDTH'(1);
        end
    end

endmodule

// File: rtl/modn_count_ctrl.sv
// Run sequencer around modn_updown_core: start/hold/stop, period counting, pulses.
module modn_count_ctrl
    import modn_count_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned WRAPS_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    modn_count_ctrl_if.slave  bus
);

    state_t             state, state_nxt;
    logic               mode_q;
    logic [WIDTH-1:0]   n_q;
    logic [WRAPS_W-1:0] wraps_q;
    logic [WRAPS_W-1:0] wcnt;
    logic [WRAPS_W-1:0] wcnt_inc;
    logic               wrap_q, done_q, err_q;

    logic               busy;
    logic               accept;
    logic               reject;
    logic               count_en;
    logic               wrap_evt;
    logic               final_evt;
    logic               core_dir;
    logic [WIDTH-1:0]   core_n;
    logic [WIDTH-1:0]   core_out;
    logic               core_wrap_nxt;

    // In the accept cycle the core loads from the live command, not the latch.
    always_comb begin
        busy      = (state != IDLE);
        accept    = 1'b0;
        reject    = 1'b0;
        if (state == IDLE && bus.start) begin
            accept = (bus.modulus >= WIDTH'(MIN_MODULUS));
            reject = !accept;
        end
        count_en  = busy && !bus.stop && !bus.hold;
        wrap_evt  = count_en && core_wrap_nxt;
        wcnt_inc  = (wcnt == '1) ? wcnt : wcnt + WRAPS_W'(1);
        final_evt = wrap_evt && (wraps_q != '0) && (wcnt_inc == wraps_q);
        core_dir  = accept ? bus.mode    : mode_q;
        core_n    = accept ? bus.modulus : n_q;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN, HOLD: begin
                if (bus.stop)
                    state_nxt = IDLE;
                else if (bus.hold)
                    state_nxt = HOLD;
                else if (final_evt)
                    state_nxt = IDLE;
                else
                    state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= MODE_UP;
            n_q     <= '0;
            wraps_q <= '0;
            wcnt    <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                mode_q  <= bus.mode;
                n_q     <= bus.modulus;
                wraps_q <= bus.wraps;
                wcnt    <= '0;
            end else if (wrap_evt) begin
                wcnt <= wcnt_inc;
            end
            wrap_q <= wrap_evt;
            done_q <= final_evt;
            err_q  <= reject;
        end
    end

    modn_updown_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .en       (count_en),
        .dir      (core_dir),
        .n        (core_n),
        .out      (core_out),
        .wrap_nxt (core_wrap_nxt)
    );

    assign bus.out  = core_out;
    assign bus.busy = busy;
    assign bus.wrap = wrap_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule
